// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the round-robin Mux arbiter.
//   N_REQ       : number of requesters (fixed at 4, matches the 4:1 Mux)
//   SEL_W       : select width
//   arb_state_t : IDLE / BUSY
//   sel_t       : requester index / Mux select
//   onehot()    : index -> one-hot requester mask
package mux_arb_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = $clog2(N_REQ);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;
  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [N_REQ-1:0] onehot(input sel_t s);
    onehot    = '0;
    onehot[s] = 1'b1;
  endfunction
endpackage

// File: rtl/mux_rr_arbiter_mux4.sv
// One-bit 4:1 Mux; the arbiter instantiates one per data bit.
//   i_d   : one bit from each requester
//   i_sel : select
//   o_y   : selected bit
module mux4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_d,
  input  sel_t             i_sel,
  output logic             o_y
);
  assign o_y = i_d[i_sel];
endmodule

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   i_mask  : candidate requesters
//   i_start : index searched first; scan wraps modulo N_REQ
//   o_found : any candidate present
//   o_idx   : first candidate at or after i_start
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_mask,
  input  sel_t             i_start,
  output logic             o_found,
  output sel_t             o_idx
);
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_start;
    for (int k = 0; k < N_REQ; k++) begin
      // sel_t addition wraps naturally because N_REQ is a power of two
      if (!o_found && i_mask[i_start + sel_t'(k)]) begin
        o_found = 1'b1;
        o_idx   = i_start + sel_t'(k);
      end
    end
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 Mux datapath between four requesters.
// Picks a pending requester, drives the registered Mux select, presents the
// word under valid/ready and pulses grant to the winner on accept. On accept
// it re-arbitrates in the same cycle, so streams run with no bubbles.
// Optional macro MUX_ARB_LOCK_EN: a locked owner may keep the grant for up
// to MAX_HOLD consecutive beats.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   req        : per-requester request, held until its grant pulses
//   data_in    : packed data, slice i belongs to req[i]
//   lock       : ownership lock (only with MUX_ARB_LOCK_EN)
//   select     : registered Mux select = current owner
//   out_valid  : downstream valid
//   out_data   : data_in slice at select
//   out_ready  : downstream accept
//   grant      : one-hot pulse on the accept cycle
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  input  logic [N_REQ-1:0]        lock,
  output logic [SEL_W-1:0]        select,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
  output logic [N_REQ-1:0]        grant
);
  arb_state_t       r_state, w_nxt_state;
  sel_t             r_sel, w_nxt_sel, r_ptr, w_nxt_ptr;
  logic             w_busy, w_accept, w_viol, w_keep, w_found;
  sel_t             w_sel_p1, w_start, w_win;
  logic [N_REQ-1:0] w_mask;

  assign w_busy   = (r_state == BUSY);
  assign w_sel_p1 = r_sel + 1'b1;
  // An owner that dropped its request is a protocol violation, never an accept
  assign w_accept = w_busy & out_ready & req[r_sel];
  assign w_viol   = w_busy & ~req[r_sel];

  // One picker serves both the IDLE pick and the back-to-back pick
  assign w_mask  = w_busy ? (req & ~onehot(r_sel)) : req;
  assign w_start = w_busy ? w_sel_p1 : r_ptr;

  rr_pick u_pick (
    .i_mask  (w_mask),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_win)
  );

`ifdef MUX_ARB_LOCK_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [HOLD_W-1:0] r_hold, w_nxt_hold;

  assign w_keep = w_accept & lock[r_sel] & (r_hold < HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    w_nxt_hold = r_hold;
    if (w_keep)                         w_nxt_hold = r_hold + 1'b1;
    else if (w_viol || w_accept)        w_nxt_hold = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hold <= '0;
    else        r_hold <= w_nxt_hold;
  end
`else
  logic w_unused;
  assign w_unused = ^{lock, MAX_HOLD[0]};
  assign w_keep   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_sel   <= w_nxt_sel;
      r_ptr   <= w_nxt_ptr;
    end
  end

  // Next-state logic
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_sel   = r_sel;
    w_nxt_ptr   = r_ptr;
    case (r_state)
      IDLE: if (w_found) begin
        w_nxt_state = BUSY;
        w_nxt_sel   = w_win;
      end
      BUSY: begin
        if (w_viol) begin
          w_nxt_state = IDLE;
        end else if (w_accept && !w_keep) begin
          w_nxt_ptr = w_sel_p1;
          if (w_found) w_nxt_sel   = w_win;
          else         w_nxt_state = IDLE;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    out_valid = w_busy;
    grant     = w_accept ? onehot(r_sel) : '0;
  end
  assign select = r_sel;

  // Bit-sliced Mux: column b gathers bit b of every requester's word
  logic [DATA_W-1:0][N_REQ-1:0] w_col;
  for (genvar b = 0; b < DATA_W; b++) begin : g_bit
    for (genvar i = 0; i < N_REQ; i++) begin : g_req
      assign w_col[b][i] = data_in[i*DATA_W + b];
    end
    mux4 u_mux (
      .i_d   (w_col[b]),
      .i_sel (r_sel),
      .o_y   (out_data[b])
    );
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
  localparam int DW = 8;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req, lock, grant;
  logic [4*DW-1:0] data_in;
  logic [1:0]    select;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;
  bit done  = 1'b0;

  mux_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .lock(lock),
    .select(select), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: owner / priority pointer / hold count ----
  bit m_busy;
  int m_sel, m_ptr, m_hold;

  function automatic int scan(input logic [3:0] m, input int start);
    for (int k = 0; k < 4; k++)
      if (m[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  function automatic bit keep_owner(input int s, input int h, input logic [3:0] lk);
`ifdef MUX_ARB_LOCK_EN
    return lk[s] && (h < MH - 1);
`else
    return 1'b0 && lk[s] && (h < 0);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_sel <= 0; m_ptr <= 0; m_hold <= 0;
    end else if (!m_busy) begin
      if (scan(req, m_ptr) >= 0) begin
        m_busy <= 1'b1;
        m_sel  <= scan(req, m_ptr);
      end
    end else if (!req[m_sel]) begin
      m_busy <= 1'b0;
      m_hold <= 0;
    end else if (out_ready) begin
      if (keep_owner(m_sel, m_hold, lock)) begin
        m_hold <= m_hold + 1;
      end else begin
        m_hold <= 0;
        m_ptr  <= (m_sel + 1) % 4;
        if (scan(req & ~(4'b1 << m_sel), (m_sel + 1) % 4) >= 0)
          m_sel <= scan(req & ~(4'b1 << m_sel), (m_sel + 1) % 4);
        else
          m_busy <= 1'b0;
      end
    end
  end

  // ---- per-cycle compare against the model ----
  always @(negedge clk) begin
    if (!done) begin
      chk("m_valid",  {31'b0, out_valid}, {31'b0, m_busy});
      chk("m_grant",  {28'b0, grant},
          (m_busy && out_ready && req[m_sel]) ? (32'd1 << m_sel) : 32'd0);
      if (m_busy) begin
        chk("m_select", {30'b0, select}, m_sel);
        chk("m_data",   {24'b0, out_data}, {24'b0, data_in[m_sel*DW +: DW]});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic at_neg();
    @(negedge clk);
  endtask

  logic [3:0] exp_alt [5];

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; out_ready = 1'b0;
    data_in = {8'h33, 8'hA5, 8'h22, 8'h11};
`ifdef MUX_ARB_LOCK_EN
    exp_alt = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
`else
    exp_alt = '{4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif

    // power-on reset
    at_neg();
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_sel",   {30'b0, select}, 0);
    chk("rst_grant", {28'b0, grant}, 0);
    tick(); rst_n = 1'b1;

    // single requester
    req = 4'b0100; out_ready = 1'b1;
    at_neg(); chk("single_lat0", {31'b0, out_valid}, 0);
    tick();
    at_neg();
    chk("single_valid", {31'b0, out_valid}, 1);
    chk("single_sel",   {30'b0, select}, 2);
    chk("single_data",  {24'b0, out_data}, 32'hA5);
    chk("single_grant", {28'b0, grant}, 32'b0100);
    tick(); req = 4'b0000;
    at_neg();
    chk("single_gone",  {28'b0, grant}, 0);
    chk("single_idle",  {31'b0, out_valid}, 0);

    // reset asserted mid-BUSY
    req = 4'b1111; out_ready = 1'b0;
    tick();
    at_neg(); chk("pre_rst_sel", {30'b0, select}, 3);
    tick(); out_ready = 1'b1; rst_n = 1'b0;
    at_neg();
    chk("mid_rst_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_grant", {28'b0, grant}, 0);
    chk("mid_rst_sel",   {30'b0, select}, 0);
    tick(); rst_n = 1'b1;
    at_neg(); chk("post_rst_idle", {31'b0, out_valid}, 0);
    tick();

    // round robin, no bubbles
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk($sformatf("rr_grant%0d", i), {28'b0, grant}, 32'd1 << (i % 4));
      tick();
    end
    req = 4'b1010; out_ready = 1'b0;

    // backpressure
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk($sformatf("bp_sel%0d", i),   {30'b0, select}, 1);
      chk($sformatf("bp_data%0d", i),  {24'b0, out_data}, 32'h22);
      chk($sformatf("bp_grant%0d", i), {28'b0, grant}, 0);
      tick();
    end
    out_ready = 1'b1;
    at_neg(); chk("bp_rel_g1", {28'b0, grant}, 32'b0010);
    tick(); req = 4'b1000;
    at_neg();
    chk("bp_rel_g3",   {28'b0, grant}, 32'b1000);
    chk("bp_rel_data", {24'b0, out_data}, 32'h33);
    tick(); req = 4'b0000; out_ready = 1'b0;
    at_neg(); chk("bp_idle", {31'b0, out_valid}, 0);

    // protocol violation: req[3] drops while selected
    req = 4'b1000;
    tick();
    at_neg(); chk("viol_sel", {30'b0, select}, 3);
    tick(); req = 4'b0000;
    at_neg(); chk("viol_nogrant", {28'b0, grant}, 0);
    tick();
    at_neg();
    chk("viol_valid", {31'b0, out_valid}, 0);
    chk("viol_grant", {28'b0, grant}, 0);
    req = 4'b1001;
    tick();
    at_neg(); chk("viol_ptr", {30'b0, select}, 0);
    tick(); req = 4'b0001; out_ready = 1'b1;
    at_neg(); chk("pre_alt_g0", {28'b0, grant}, 32'b0001);

    // alternation (or locked owner with MUX_ARB_LOCK_EN)
    tick(); req = 4'b0011; lock = 4'b0010;
    at_neg(); chk("alt_idle", {31'b0, out_valid}, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk($sformatf("alt_grant%0d", i), {28'b0, grant}, {28'b0, exp_alt[i]});
      tick();
    end
    req = '0; lock = '0; out_ready = 1'b0;
    tick(); tick();
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
